// File: rtl/dpram_pkg.sv
// Shared definitions for the dual-port RAM read-side streamer: FSM state
// encodings and the width helper for the credit and occupancy counters.
package dpram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

  // A counter must be able to hold the value `depth`, not just depth-1.
  function automatic int credit_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dpram_rd_fifo.sv
// Small synchronous FIFO for the read streamer. The head entry is read from a
// register and the valid flag is registered, so a pushed word appears one cycle later.
module dpram_rd_fifo
  import dpram_pkg::*;
#(
  parameter int DW         = 64,
  parameter int FIFO_DEPTH = 4,
  localparam int CW        = credit_w(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [CW-1:0] count_o,
  output logic          valid_o,
  output logic [DW-1:0] data_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q;

  // Pointers wrap explicitly so a non-power-of-two depth still works.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign count_d = count_q + CW'(push_i) - CW'(pop_i);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_i) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_d;
      valid_q <= (count_d != '0);
    end
  end

  assign count_o = count_q;
  assign valid_o = valid_q;
  assign data_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/dpram_stream_reader.sv
// Sequential reader over an address window of the dual-port RAM, delivered as a
// valid/ready stream. Optional stall counter port enabled by DPRAM_RD_STALL_CNT_EN.
module dpram_stream_reader
  import dpram_pkg::*;
#(
  parameter int DW         = 64,
  parameter int AW         = 8,
  parameter int N_DELAY    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   num_words,
  output logic          busy,
  output logic          done,
  output logic          ram_enb,
  output logic [AW-1:0] ram_addrb,
  input  logic [DW-1:0] ram_dob,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last
`ifdef DPRAM_RD_STALL_CNT_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  localparam int CW = credit_w(FIFO_DEPTH);
  localparam logic [CW:0] DEPTH_C = FIFO_DEPTH[CW:0];

  rd_state_e          state_q;
  logic               busy_q, done_q, enb_q, issue_q;
  logic [AW-1:0]      addr_q, base_q;
  logic [AW:0]        num_q, last_idx_q;
  logic [AW:0]        issue_cnt_q, issue_cnt_d, pop_cnt_q, pop_cnt_d;
  logic [CW-1:0]      inflight_q, inflight_d, fifo_count, fifo_count_d;
  logic [CW:0]        credit_d;
  logic [N_DELAY-1:0] tag_q;
  logic [N_DELAY:0]   tag_sh;
  logic               push, pop;

  // A tag reaching the end of the shift register marks ram_dob as a wanted word.
  assign push   = enb_q & tag_q[N_DELAY-1];
  assign pop    = m_valid & m_ready;
  assign tag_sh = {tag_q, issue_q};

  // Next-cycle counter values; the issue decision for the coming cycle uses them.
  always_comb begin
    issue_cnt_d  = issue_cnt_q + {{AW{1'b0}}, issue_q};
    pop_cnt_d    = pop_cnt_q + {{AW{1'b0}}, pop};
    inflight_d   = inflight_q + CW'(issue_q) - CW'(push);
    fifo_count_d = fifo_count + CW'(push) - CW'(pop);
    credit_d     = {1'b0, inflight_d} + {1'b0, fifo_count_d};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      enb_q       <= 1'b0;
      issue_q     <= 1'b0;
      addr_q      <= '0;
      base_q      <= '0;
      num_q       <= '0;
      last_idx_q  <= '0;
      issue_cnt_q <= '0;
      pop_cnt_q   <= '0;
      inflight_q  <= '0;
      tag_q       <= '0;
    end else begin
      done_q      <= 1'b0;
      issue_q     <= 1'b0;
      issue_cnt_q <= issue_cnt_d;
      pop_cnt_q   <= pop_cnt_d;
      inflight_q  <= inflight_d;
      if (enb_q) tag_q <= tag_sh[N_DELAY-1:0];
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (num_words != '0) begin
              state_q     <= ST_RUN;
              busy_q      <= 1'b1;
              enb_q       <= 1'b1;
              base_q      <= base_addr;
              num_q       <= num_words;
              last_idx_q  <= num_words - {{AW{1'b0}}, 1'b1};
              issue_cnt_q <= '0;
              pop_cnt_q   <= '0;
              inflight_q  <= '0;
              issue_q     <= 1'b1;
              addr_q      <= base_addr;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (issue_cnt_d == num_q) begin
            state_q <= ST_DRAIN;
          end else if (credit_d < DEPTH_C) begin
            issue_q <= 1'b1;
            addr_q  <= base_q + issue_cnt_d[AW-1:0];
          end
        end
        ST_DRAIN: begin
          if (pop && m_last) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            enb_q   <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  dpram_rd_fifo #(
    .DW         (DW),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .push_i      (push),
    .push_data_i (ram_dob),
    .pop_i       (pop),
    .count_o     (fifo_count),
    .valid_o     (m_valid),
    .data_o      (m_data)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign ram_enb   = enb_q;
  assign ram_addrb = addr_q;
  assign m_last    = m_valid & (pop_cnt_q == last_idx_q);

`ifdef DPRAM_RD_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_q <= '0;
    end else if (state_q == ST_IDLE && start) begin
      stall_q <= '0;
    end else if (m_valid && !m_ready && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Randomized self-checking bench for dpram_stream_reader with a latency-accurate
// RAM model; the expected stream is built from the window rules over the RAM array.
module tb_dpram_stream_reader;

  localparam int DW         = 64;
  localparam int AW         = 8;
  localparam int N_DELAY    = 2;
  localparam int FIFO_DEPTH = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_words;
  logic          busy, done, ram_enb, m_valid, m_ready, m_last;
  logic [AW-1:0] ram_addrb;
  logic [DW-1:0] ram_dob, m_data;
`ifdef DPRAM_RD_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int max_credit = 0;

  logic [DW-1:0] mem  [256];
  logic [DW-1:0] pipe [N_DELAY];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dpram_stream_reader #(
    .DW(DW), .AW(AW), .N_DELAY(N_DELAY), .FIFO_DEPTH(FIFO_DEPTH)
  ) u_dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
    .num_words(num_words), .busy(busy), .done(done), .ram_enb(ram_enb),
    .ram_addrb(ram_addrb), .ram_dob(ram_dob), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
`ifdef DPRAM_RD_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // RAM read port: N_DELAY-stage pipeline that only advances while enabled.
  always @(posedge clk) begin
    if (ram_enb) begin
      pipe[0] <= mem[ram_addrb];
      for (int k = 1; k < N_DELAY; k++) pipe[k] <= pipe[k-1];
    end
  end
  assign ram_dob = pipe[N_DELAY-1];

  always @(negedge clk) begin
    if (rstn && (int'(u_dut.inflight_q) + int'(u_dut.fifo_count)) > max_credit)
      max_credit = int'(u_dut.inflight_q) + int'(u_dut.fifo_count);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_enb"}, ram_enb, 0);
    chk({nm, "_addr"}, ram_addrb, 0);
    chk({nm, "_valid"}, m_valid, 0);
    chk({nm, "_data"}, m_data, 0);
    chk({nm, "_last"}, m_last, 0);
`ifdef DPRAM_RD_STALL_CNT_EN
    chk({nm, "_stall"}, stall_cnt, 0);
`endif
  endtask

  // mode 0: always ready, 1: ready one cycle in three, 2: ten stalls at first valid
  task automatic run_xfer(input logic [AW-1:0] base, input logic [AW:0] num,
                          input int mode, input string nm);
    logic [DW-1:0] expq[$];
    logic [DW-1:0] e, prev_data;
    logic prev_stall, prev_last, fin;
    int rel, first_vld, last_hs, done_rel, popped, stalls, budget;
    for (int i = 0; i < int'(num); i++) expq.push_back(mem[(int'(base) + i) % 256]);
    first_vld = -1; last_hs = -1; done_rel = -1; popped = 0; stalls = 0;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0; fin = 1'b0;
    budget = int'(num) * 8 + 50;
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; num_words = num;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < budget && !fin; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      rel = k + 1;
      case (mode)
        1: m_ready = ($urandom_range(0, 2) == 0);
        2: if (m_valid && stalls < 10) begin m_ready = 1'b0; stalls++; end
           else m_ready = 1'b1;
        default: m_ready = 1'b1;
      endcase
      #4;
      if (rel == 1) begin
        chk({nm, "_busy1"}, busy, 1);
        chk({nm, "_enb1"}, ram_enb, 1);
        chk({nm, "_addr1"}, ram_addrb, base);
`ifdef DPRAM_RD_STALL_CNT_EN
        chk({nm, "_stall_clr"}, stall_cnt, 0);
`endif
      end
      if (prev_stall) begin
        chk({nm, "_hold_v"}, m_valid, 1);
        chk({nm, "_hold_d"}, m_data, prev_data);
        chk({nm, "_hold_l"}, m_last, prev_last);
      end
      if (m_valid && first_vld < 0) first_vld = rel;
      if (m_valid && m_ready) begin
        if (expq.size() == 0) chk({nm, "_extra"}, 1, 0);
        else begin
          e = expq.pop_front();
          chk({nm, "_data"}, m_data, e);
          chk({nm, "_last"}, m_last, (expq.size() == 0));
        end
        last_hs = rel;
        popped++;
      end
      if (done) begin
        done_rel = rel;
        fin = 1'b1;
        chk({nm, "_busy_done"}, busy, 0);
      end
      prev_stall = m_valid & ~m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
    chk({nm, "_done_seen"}, fin, 1);
    chk({nm, "_count"}, popped, num);
    if (mode == 0) begin
      chk({nm, "_first_vld"}, first_vld, 2 + N_DELAY);
      chk({nm, "_last_hs"}, last_hs, int'(num) + 1 + N_DELAY);
      chk({nm, "_done_cyc"}, done_rel, int'(num) + 2 + N_DELAY);
    end else begin
      chk({nm, "_done_after"}, done_rel, last_hs + 1);
    end
    if (fin) begin
      @(posedge clk); #5;
      chk({nm, "_done_pulse"}, done, 0);
      chk({nm, "_enb_idle"}, ram_enb, 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; start = 1'b0; base_addr = '0; num_words = '0; m_ready = 1'b1;
    for (int a = 0; a < 256; a++) mem[a] = DW'(a);
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
    rstn = 1'b1;

    run_xfer(8'h10, 9'd4, 0, "b2b");
    run_xfer(8'hFE, 9'd4, 0, "wrap");
    run_xfer(8'h20, 9'd16, 1, "bp");

    // Zero-length start
    @(posedge clk); #1;
    start = 1'b1; num_words = '0; base_addr = 8'h55;
    @(posedge clk); #1;
    start = 1'b0;
    #4;
    chk("zl_done", done, 1);
    chk("zl_busy", busy, 0);
    chk("zl_enb", ram_enb, 0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #5;
      chk("zl_done_once", done, 0);
      chk("zl_valid", m_valid, 0);
      chk("zl_enb_late", ram_enb, 0);
    end

    // Reset during a long transfer
    @(posedge clk); #1;
    start = 1'b1; num_words = 9'd32; base_addr = 8'h80;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk_zero("midrst");
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    run_xfer(8'h40, 9'd2, 0, "post_rst");

`ifdef DPRAM_RD_STALL_CNT_EN
    run_xfer(8'h30, 9'd6, 2, "stall");
    chk("stall_cnt_10", stall_cnt, 16'd10);
    run_xfer(8'h31, 9'd3, 0, "stall_next");
    chk("stall_cnt_after", stall_cnt, 16'd0);
`endif

    for (int a = 0; a < 256; a++) mem[a] = {$urandom, $urandom};
    run_xfer(8'hC3, 9'd256, 0, "full");
    for (int t = 0; t < 12; t++) begin
      run_xfer(AW'($urandom), 9'($urandom_range(1, 40)), int'($urandom_range(0, 2)), "rnd");
    end

    chk("credit_max", (max_credit <= FIFO_DEPTH), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
